// File: rtl/led_pwm_blink_user_logic.sv
// rtl/led_pwm_blink_user_logic.sv - register-controlled LED pattern driver with blink and PWM gating
module led_pwm_blink_user_logic #(
   parameter int LED_WIDTH      = 8,
   parameter int PWM_BITS       = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic                 slv_reg_wren,
   input  logic [2:0]           axi_awaddr,
   input  logic [31:0]          S_AXI_WDATA,
   input  logic [2:0]           rd_addr,
   output logic [31:0]          rdata,
   output logic [LED_WIDTH-1:0] LED,
   output logic                 blink_phase
);

   localparam logic [2:0] IDX_ID       = 3'd0;
   localparam logic [2:0] IDX_PATTERN  = 3'd1;
   localparam logic [2:0] IDX_MODE     = 3'd2;
   localparam logic [2:0] IDX_PRESCALE = 3'd3;
   localparam logic [2:0] IDX_DUTY     = 3'd4;
   localparam logic [2:0] IDX_BLINK    = 3'd5;

   localparam logic [31:0] ID_WORD = {8'(PWM_BITS), 8'(LED_WIDTH), 16'h0002};

   localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = 1;
   localparam logic [PWM_BITS-1:0]       PWM_ONE   = 1;
   localparam logic [15:0]               BLINK_ONE = 16'd1;

   // Gate selection encodings held in MODE
   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_PWM    = 2'd2;
   localparam logic [1:0] MODE_BOTH   = 2'd3;

   // Software-visible registers
   logic [LED_WIDTH-1:0]      pattern;
   logic [1:0]                mode;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [PWM_BITS-1:0]       duty;
   logic [15:0]               blink_half;

   // Free-running state
   logic [PRESCALE_WIDTH-1:0] presc_cnt;
   logic [PWM_BITS-1:0]       pwm_cnt;
   logic [15:0]               blink_cnt;

   // Decoded write strobes, one per writable register
   logic wr_pattern;
   logic wr_mode;
   logic wr_prescale;
   logic wr_duty;
   logic wr_blink;

   logic tick;
   logic pwm_on;
   logic gate;

   // Upper write-data bits beyond each register's width are intentionally dropped
   logic unused_wdata;
   assign unused_wdata = ^S_AXI_WDATA;

   // Address decode of the write strobe
   always_comb begin
      wr_pattern  = slv_reg_wren && (axi_awaddr == IDX_PATTERN);
      wr_mode     = slv_reg_wren && (axi_awaddr == IDX_MODE);
      wr_prescale = slv_reg_wren && (axi_awaddr == IDX_PRESCALE);
      wr_duty     = slv_reg_wren && (axi_awaddr == IDX_DUTY);
      wr_blink    = slv_reg_wren && (axi_awaddr == IDX_BLINK);
   end

   // Tick fires on the last count of the prescale period
   assign tick = (presc_cnt == prescale);

   // Full-scale duty is forced on so the LED never drops for one count per period
   assign pwm_on = (duty == {PWM_BITS{1'b1}}) || (pwm_cnt < duty);

   // Per-mode gate applied to the pattern
   always_comb begin
      gate = 1'b1;
      case (mode)
         MODE_STATIC: gate = 1'b1;
         MODE_BLINK:  gate = blink_phase;
         MODE_PWM:    gate = pwm_on;
         MODE_BOTH:   gate = blink_phase & pwm_on;
         default:     gate = 1'b1;
      endcase
   end

   // Register file writes; index 0, 6 and 7 have no storage
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         pattern    <= '0;
         mode       <= '0;
         prescale   <= '0;
         duty       <= '0;
         blink_half <= '0;
      end else begin
         if (wr_pattern)  pattern    <= S_AXI_WDATA[LED_WIDTH-1:0];
         if (wr_mode)     mode       <= S_AXI_WDATA[1:0];
         if (wr_prescale) prescale   <= S_AXI_WDATA[PRESCALE_WIDTH-1:0];
         if (wr_duty)     duty       <= S_AXI_WDATA[PWM_BITS-1:0];
         if (wr_blink)    blink_half <= S_AXI_WDATA[15:0];
      end
   end

   // Prescaler and PWM counter; a PRESCALE write restarts both, beating the tick
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
      end else if (wr_prescale) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
      end else if (tick) begin
         presc_cnt <= '0;
         pwm_cnt   <= pwm_cnt + PWM_ONE;
      end else begin
         presc_cnt <= presc_cnt + PRESC_ONE;
      end
   end

   // Blink half-period counter; a BLINK_HALF write restarts in the on half, beating the tick
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_blink) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == blink_half) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_ONE;
         end
      end
   end

   // LED output register: pattern masked by the current gate
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         LED <= '0;
      end else begin
         LED <= gate ? pattern : '0;
      end
   end

   // Combinational readback, zero-extended to 32 bits
   always_comb begin
      rdata = '0;
      case (rd_addr)
         IDX_ID:       rdata = ID_WORD;
         IDX_PATTERN:  rdata = 32'(pattern);
         IDX_MODE:     rdata = 32'(mode);
         IDX_PRESCALE: rdata = 32'(prescale);
         IDX_DUTY:     rdata = 32'(duty);
         IDX_BLINK:    rdata = 32'(blink_half);
         default:      rdata = '0;
      endcase
   end

endmodule
